// File: rtl/rv_lsu_pkg.sv
// Shared types for the load/store controller: size encodings, FSM states and
// the access-size helper.
package rv_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ0,
      ST_WAIT0,
      ST_REQ1,
      ST_WAIT1,
      ST_RESP
   } lsu_state_e;

   // Number of bytes touched by an access of the given funct3.
   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      return 4'd1 << funct3[1:0];
   endfunction

endpackage

// File: rtl/rv_lsu_ctrl_if.sv
// Bundles for the load/store controller: the pipeline-side request/response
// channel and the word-organised memory beat channel.
interface rv_lsu_req_if #(
   parameter int XLEN = 64,
   parameter int AW   = 64
);
   import rv_lsu_pkg::*;

   logic            req_valid_i;
   logic            req_ready_o;
   logic            req_we_i;
   logic [2:0]      funct3_i;
   logic [AW-1:0]   addr_i;
   logic [XLEN-1:0] wr_data_i;
   logic            resp_valid_o;
   logic            resp_err_o;
   logic [XLEN-1:0] rd_data_o;

   // Pipeline side issues requests and consumes responses.
   modport master (
      output req_valid_i, req_we_i, funct3_i, addr_i, wr_data_i,
      input  req_ready_o, resp_valid_o, resp_err_o, rd_data_o
   );

   // Controller side.
   modport slave (
      input  req_valid_i, req_we_i, funct3_i, addr_i, wr_data_i,
      output req_ready_o, resp_valid_o, resp_err_o, rd_data_o
   );
endinterface

interface rv_lsu_mem_if #(
   parameter int XLEN = 64,
   parameter int AW   = 64
);
   import rv_lsu_pkg::*;

   localparam int BYTES = XLEN / 8;
   localparam int OFFW  = $clog2(BYTES);

   logic               mem_req_o;
   logic               mem_we_o;
   logic [AW-OFFW-1:0] mem_addr_o;
   logic [BYTES-1:0]   mem_strb_o;
   logic [XLEN-1:0]    mem_wdata_o;
   logic               mem_gnt_i;
   logic               mem_rvalid_i;
   logic [XLEN-1:0]    mem_rdata_i;

   // Controller side issues beats.
   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_strb_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   // Memory side grants beats and returns read words.
   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_strb_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/rv_lsu_align.sv
// Lane alignment for one memory beat (strobes, shifted store data) and the
// merge/extend of up to two captured read words into the load result.
module rv_lsu_align
   import rv_lsu_pkg::*;
#(
   parameter  int XLEN  = 64,
   localparam int BYTES = XLEN / 8,
   localparam int OFFW  = $clog2(BYTES)
) (
   input  logic [OFFW-1:0]  off,
   input  logic [1:0]       size,
   input  logic             is_unsigned,
   input  logic             beat1,
   input  logic [XLEN-1:0]  wr_data,
   input  logic [XLEN-1:0]  lo,
   input  logic [XLEN-1:0]  hi,
   output logic [BYTES-1:0] strb,
   output logic [XLEN-1:0]  wdata,
   output logic [XLEN-1:0]  rd_data
);

   logic [3:0]         n;
   logic [BYTES-1:0]   mask;
   logic [2*BYTES-1:0] strb_wide;
   logic [2*XLEN-1:0]  wdata_wide;

   // Lay the access across two adjacent words; beat 1 takes the upper word.
   always_comb begin
      n          = size_bytes({1'b0, size});
      mask       = BYTES'((16'd1 << n) - 16'd1);
      strb_wide  = {{BYTES{1'b0}}, mask} << off;
      wdata_wide = {{XLEN{1'b0}}, wr_data} << {off, 3'b000};
      strb       = beat1 ? strb_wide[2*BYTES-1:BYTES] : strb_wide[BYTES-1:0];
      wdata      = beat1 ? wdata_wide[2*XLEN-1:XLEN] : wdata_wide[XLEN-1:0];
   end

   logic [XLEN-1:0] raw;
   logic            msb;
   logic            ext;
   int              nbits;

   // Shift the {hi,lo} pair down to the access offset, then sign/zero extend.
   always_comb begin
      raw = XLEN'({hi, lo} >> {off, 3'b000});
      case (size)
         SZ_B:    msb = raw[7];
         SZ_H:    msb = raw[15];
         SZ_W:    msb = raw[31];
         default: msb = raw[XLEN-1];
      endcase
      ext     = ~is_unsigned & msb;
      nbits   = 8 * int'(n);
      rd_data = '0;
      for (int i = 0; i < XLEN; i++)
         rd_data[i] = (i < nbits) ? raw[i] : ext;
   end

endmodule

// File: rtl/rv_lsu_ctrl.sv
// Load/store controller: accepts one access at a time, issues one or two
// memory beats through a handshake FSM and returns the aligned load result.
module rv_lsu_ctrl
   import rv_lsu_pkg::*;
#(
   parameter  int XLEN        = 64,
   parameter  int AW          = 64,
   parameter  bit MISALIGN_EN = 1'b1,
   localparam int BYTES       = XLEN / 8,
   localparam int OFFW        = $clog2(BYTES)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   rv_lsu_req_if.slave  req,
   rv_lsu_mem_if.master mem
);

   lsu_state_e      state_q, state_d;
   logic            we_q;
   logic [2:0]      f3_q;
   logic [AW-1:0]   addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] lo_q, hi_q;
   logic            err_q;
   logic            cross_q;

   logic            accept;
   logic            in_illegal;
   logic            in_cross;
   logic            in_err;

   logic [BYTES-1:0] beat_strb;
   logic [XLEN-1:0]  beat_wdata;
   logic [XLEN-1:0]  load_data;
   logic [AW-OFFW-1:0] word0;

   // Decode the incoming request: boundary crossing and illegal size.
   always_comb begin
      accept     = req.req_valid_i && (state_q == ST_IDLE);
      in_illegal = (XLEN == 32) && (req.funct3_i[1:0] == SZ_D);
      in_cross   = (int'(req.addr_i[OFFW-1:0]) + int'(size_bytes(req.funct3_i))) > BYTES;
      in_err     = in_illegal || (in_cross && !MISALIGN_EN);
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Request capture and read-beat capture (beat 0 low word, beat 1 high word).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         err_q   <= 1'b0;
         cross_q <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= req.req_we_i;
            f3_q    <= req.funct3_i;
            addr_q  <= req.addr_i;
            wdata_q <= req.wr_data_i;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= in_err;
            cross_q <= in_cross && !in_illegal;
         end
         if (state_q == ST_WAIT0 && mem.mem_rvalid_i) lo_q <= mem.mem_rdata_i;
         if (state_q == ST_WAIT1 && mem.mem_rvalid_i) hi_q <= mem.mem_rdata_i;
      end
   end

   assign word0 = addr_q[AW-1:OFFW];

   rv_lsu_align #(.XLEN(XLEN)) u_align (
      .off         (addr_q[OFFW-1:0]),
      .size        (f3_q[1:0]),
      .is_unsigned (f3_q[2]),
      .beat1       (state_q == ST_REQ1),
      .wr_data     (wdata_q),
      .lo          (lo_q),
      .hi          (hi_q),
      .strb        (beat_strb),
      .wdata       (beat_wdata),
      .rd_data     (load_data)
   );

   // Next state and all outputs; memory signals are held stable while in REQ.
   always_comb begin
      state_d          = state_q;
      req.req_ready_o  = 1'b0;
      req.resp_valid_o = 1'b0;
      req.resp_err_o   = 1'b0;
      req.rd_data_o    = '0;
      mem.mem_req_o    = 1'b0;
      mem.mem_we_o     = 1'b0;
      mem.mem_addr_o   = '0;
      mem.mem_strb_o   = '0;
      mem.mem_wdata_o  = '0;

      case (state_q)
         ST_IDLE: begin
            req.req_ready_o = 1'b1;
            if (req.req_valid_i) state_d = ST_REQ0;
         end
         ST_REQ0: begin
            if (err_q) begin
               state_d = ST_RESP;
            end else begin
               mem.mem_req_o   = 1'b1;
               mem.mem_we_o    = we_q;
               mem.mem_addr_o  = word0;
               mem.mem_strb_o  = beat_strb;
               mem.mem_wdata_o = beat_wdata;
               if (mem.mem_gnt_i)
                  state_d = !we_q ? ST_WAIT0 : (cross_q ? ST_REQ1 : ST_RESP);
            end
         end
         ST_WAIT0: begin
            if (mem.mem_rvalid_i) state_d = cross_q ? ST_REQ1 : ST_RESP;
         end
         ST_REQ1: begin
            mem.mem_req_o   = 1'b1;
            mem.mem_we_o    = we_q;
            mem.mem_addr_o  = word0 + (AW-OFFW)'(1);
            mem.mem_strb_o  = beat_strb;
            mem.mem_wdata_o = beat_wdata;
            if (mem.mem_gnt_i) state_d = we_q ? ST_RESP : ST_WAIT1;
         end
         ST_WAIT1: begin
            if (mem.mem_rvalid_i) state_d = ST_RESP;
         end
         ST_RESP: begin
            req.resp_valid_o = 1'b1;
            req.resp_err_o   = err_q;
            req.rd_data_o    = (!we_q && !err_q) ? load_data : '0;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_rv_lsu_ctrl.sv
// Directed bench for rv_lsu_ctrl: three instances (split enabled, split
// disabled, 32-bit) share stimulus; a vector table covers single transactions
// and hand sequences cover stalls, mid-access reset and stray rvalid.
module tb_rv_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, we, gnt, rvalid;
   logic [2:0]  f3;
   logic [63:0] addr, wdata, rdata;
   logic [1:0]  sel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv_lsu_req_if #(.XLEN(64), .AW(64)) req0 ();
   rv_lsu_mem_if #(.XLEN(64), .AW(64)) m0 ();
   rv_lsu_req_if #(.XLEN(64), .AW(64)) req1 ();
   rv_lsu_mem_if #(.XLEN(64), .AW(64)) m1 ();
   rv_lsu_req_if #(.XLEN(32), .AW(64)) req2 ();
   rv_lsu_mem_if #(.XLEN(32), .AW(64)) m2 ();

   rv_lsu_ctrl #(.XLEN(64), .AW(64), .MISALIGN_EN(1'b1)) dut0 (.clk_i(clk), .rst_i(rst), .req(req0), .mem(m0));
   rv_lsu_ctrl #(.XLEN(64), .AW(64), .MISALIGN_EN(1'b0)) dut1 (.clk_i(clk), .rst_i(rst), .req(req1), .mem(m1));
   rv_lsu_ctrl #(.XLEN(32), .AW(64), .MISALIGN_EN(1'b1)) dut2 (.clk_i(clk), .rst_i(rst), .req(req2), .mem(m2));

   assign req0.req_valid_i = valid & (sel == 2'd0);
   assign req1.req_valid_i = valid & (sel == 2'd1);
   assign req2.req_valid_i = valid & (sel == 2'd2);
   assign req0.req_we_i = we;
   assign req1.req_we_i = we;
   assign req2.req_we_i = we;
   assign req0.funct3_i = f3;
   assign req1.funct3_i = f3;
   assign req2.funct3_i = f3;
   assign req0.addr_i = addr;
   assign req1.addr_i = addr;
   assign req2.addr_i = addr;
   assign req0.wr_data_i = wdata;
   assign req1.wr_data_i = wdata;
   assign req2.wr_data_i = wdata[31:0];
   assign m0.mem_gnt_i = gnt;
   assign m1.mem_gnt_i = gnt;
   assign m2.mem_gnt_i = gnt;
   assign m0.mem_rvalid_i = rvalid;
   assign m1.mem_rvalid_i = rvalid;
   assign m2.mem_rvalid_i = rvalid;
   assign m0.mem_rdata_i = rdata;
   assign m1.mem_rdata_i = rdata;
   assign m2.mem_rdata_i = rdata[31:0];

   // Observed outputs of the selected instance, widened to 64 bits.
   logic        o_ready, o_resp, o_err, o_mreq, o_mwe;
   logic [63:0] o_rd, o_maddr, o_wdata;
   logic [7:0]  o_strb;

   always_comb begin
      o_ready = req0.req_ready_o;  o_resp = req0.resp_valid_o; o_err = req0.resp_err_o;
      o_rd    = req0.rd_data_o;    o_mreq = m0.mem_req_o;      o_mwe = m0.mem_we_o;
      o_maddr = {3'b0, m0.mem_addr_o}; o_strb = m0.mem_strb_o; o_wdata = m0.mem_wdata_o;
      case (sel)
         2'd1: begin
            o_ready = req1.req_ready_o;  o_resp = req1.resp_valid_o; o_err = req1.resp_err_o;
            o_rd    = req1.rd_data_o;    o_mreq = m1.mem_req_o;      o_mwe = m1.mem_we_o;
            o_maddr = {3'b0, m1.mem_addr_o}; o_strb = m1.mem_strb_o; o_wdata = m1.mem_wdata_o;
         end
         2'd2: begin
            o_ready = req2.req_ready_o;  o_resp = req2.resp_valid_o; o_err = req2.resp_err_o;
            o_rd    = {32'b0, req2.rd_data_o}; o_mreq = m2.mem_req_o; o_mwe = m2.mem_we_o;
            o_maddr = {2'b0, m2.mem_addr_o}; o_strb = {4'b0, m2.mem_strb_o};
            o_wdata = {32'b0, m2.mem_wdata_o};
         end
         default: ;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic        we;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rd0;
      logic [63:0] rd1;
      int          beats;
      logic [63:0] a0;
      logic [7:0]  s0;
      logic [63:0] w0;
      logic [63:0] a1;
      logic [7:0]  s1;
      logic [63:0] w1;
      int          lat;
      logic [63:0] rd;
      logic        err;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs[NV];

   // One transaction: gnt on the first REQ cycle, rvalid one cycle after gnt.
   task automatic run_vec(input vec_t v, input int id);
      int          beat;
      bit          pend;
      bit          done;
      logic [63:0] pdata;
      @(negedge clk);
      sel = v.sel; we = v.we; f3 = v.f3; addr = v.addr; wdata = v.wdata; valid = 1'b1;
      gnt = 1'b0; rvalid = 1'b0;
      chk($sformatf("v%0d_ready", id), 64'(o_ready), 64'd1);
      beat = 0; pend = 1'b0; done = 1'b0; pdata = '0;
      for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
         @(negedge clk);
         valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
         if (pend) begin
            rvalid = 1'b1; rdata = pdata; pend = 1'b0;
         end
         if (o_mreq) begin
            if (beat < v.beats) begin
               chk($sformatf("v%0d_b%0d_addr", id, beat), o_maddr, (beat == 0) ? v.a0 : v.a1);
               chk($sformatf("v%0d_b%0d_strb", id, beat), 64'(o_strb), 64'((beat == 0) ? v.s0 : v.s1));
               chk($sformatf("v%0d_b%0d_wdata", id, beat), o_wdata, (beat == 0) ? v.w0 : v.w1);
               chk($sformatf("v%0d_b%0d_we", id, beat), 64'(o_mwe), 64'(v.we));
               gnt = 1'b1;
               if (!v.we) begin
                  pend = 1'b1; pdata = (beat == 0) ? v.rd0 : v.rd1;
               end
            end else begin
               chk($sformatf("v%0d_no_extra_req", id), 64'(o_mreq), 64'd0);
            end
            beat++;
         end
         if (o_resp) begin
            done = 1'b1;
            chk($sformatf("v%0d_latency", id), 64'(cyc), 64'(v.lat));
            chk($sformatf("v%0d_rd_data", id), o_rd, v.rd);
            chk($sformatf("v%0d_err", id), 64'(o_err), 64'(v.err));
            chk($sformatf("v%0d_beats", id), 64'(beat), 64'(v.beats));
         end
      end
      gnt = 1'b0; rvalid = 1'b0;
      if (!done) chk($sformatf("v%0d_resp_timeout", id), 64'(done), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      //          sel   we    f3      addr                    wdata                   rd0                     rd1                     bts a0                      s0     w0                      a1       s1     w1                lat rd                      err
      vecs[0]  = '{2'd0, 1'b0, 3'b010, 64'h1004,               64'h0,                  64'h8000_0001_1234_5678, 64'h0,                 1, 64'h200,                8'hF0, 64'h0,                  64'h0,   8'h00, 64'h0,            3, 64'hFFFF_FFFF_8000_0001, 1'b0};
      vecs[1]  = '{2'd0, 1'b0, 3'b110, 64'h1004,               64'h0,                  64'h8000_0001_1234_5678, 64'h0,                 1, 64'h200,                8'hF0, 64'h0,                  64'h0,   8'h00, 64'h0,            3, 64'h0000_0000_8000_0001, 1'b0};
      vecs[2]  = '{2'd0, 1'b1, 3'b001, 64'h1007,               64'hABCD,               64'h0,                  64'h0,                  2, 64'h200,                8'h80, 64'hCD00_0000_0000_0000, 64'h201, 8'h01, 64'hAB,           3, 64'h0,                  1'b0};
      vecs[3]  = '{2'd0, 1'b0, 3'b011, 64'h1005,               64'h0,                  64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00, 2, 64'h200,              8'hE0, 64'h0,                  64'h201, 8'h1F, 64'h0,            5, 64'hCCDD_EEFF_0011_2233, 1'b0};
      vecs[4]  = '{2'd0, 1'b0, 3'b000, 64'h1003,               64'h0,                  64'h0000_0000_8000_0000, 64'h0,                 1, 64'h200,                8'h08, 64'h0,                  64'h0,   8'h00, 64'h0,            3, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
      vecs[5]  = '{2'd0, 1'b0, 3'b100, 64'h1003,               64'h0,                  64'h0000_0000_8000_0000, 64'h0,                 1, 64'h200,                8'h08, 64'h0,                  64'h0,   8'h00, 64'h0,            3, 64'h80,                 1'b0};
      vecs[6]  = '{2'd0, 1'b0, 3'b001, 64'h1002,               64'h0,                  64'h0000_0000_7FFF_0000, 64'h0,                 1, 64'h200,                8'h0C, 64'h0,                  64'h0,   8'h00, 64'h0,            3, 64'h7FFF,               1'b0};
      vecs[7]  = '{2'd0, 1'b1, 3'b011, 64'h2000,               64'h0123_4567_89AB_CDEF, 64'h0,                 64'h0,                  1, 64'h400,                8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0,   8'h00, 64'h0,            2, 64'h0,                  1'b0};
      vecs[8]  = '{2'd0, 1'b1, 3'b000, 64'h2005,               64'h5A,                 64'h0,                  64'h0,                  1, 64'h400,                8'h20, 64'h0000_5A00_0000_0000, 64'h0,   8'h00, 64'h0,            2, 64'h0,                  1'b0};
      vecs[9]  = '{2'd0, 1'b1, 3'b010, 64'h2006,               64'hDEAD_BEEF,          64'h0,                  64'h0,                  2, 64'h400,                8'hC0, 64'hBEEF_0000_0000_0000, 64'h401, 8'h03, 64'hDEAD,         3, 64'h0,                  1'b0};
      vecs[10] = '{2'd0, 1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0,                 64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00, 2, 64'h1FFF_FFFF_FFFF_FFFF, 8'hE0, 64'h0,              64'h0,   8'h1F, 64'h0,            5, 64'hCCDD_EEFF_0011_2233, 1'b0};
      vecs[11] = '{2'd0, 1'b0, 3'b001, 64'h1007,               64'h0,                  64'h8100_0000_0000_0000, 64'hFE,                2, 64'h200,                8'h80, 64'h0,                  64'h201, 8'h01, 64'h0,            5, 64'hFFFF_FFFF_FFFF_FE81, 1'b0};
      vecs[12] = '{2'd1, 1'b1, 3'b010, 64'h1006,               64'h1234_5678,          64'h0,                  64'h0,                  0, 64'h0,                  8'h00, 64'h0,                  64'h0,   8'h00, 64'h0,            2, 64'h0,                  1'b1};
      vecs[13] = '{2'd1, 1'b1, 3'b010, 64'h1004,               64'h1234_5678,          64'h0,                  64'h0,                  1, 64'h200,                8'hF0, 64'h1234_5678_0000_0000, 64'h0,   8'h00, 64'h0,            2, 64'h0,                  1'b0};
      vecs[14] = '{2'd2, 1'b0, 3'b011, 64'h1000,               64'h0,                  64'h0,                  64'h0,                  0, 64'h0,                  8'h00, 64'h0,                  64'h0,   8'h00, 64'h0,            2, 64'h0,                  1'b1};
      vecs[15] = '{2'd2, 1'b0, 3'b010, 64'h1004,               64'h0,                  64'h8000_0001,          64'h0,                  1, 64'h401,                8'h0F, 64'h0,                  64'h0,   8'h00, 64'h0,            3, 64'h0000_0000_8000_0001, 1'b0};
      vecs[16] = '{2'd2, 1'b1, 3'b001, 64'h1003,               64'hABCD,               64'h0,                  64'h0,                  2, 64'h400,                8'h08, 64'hCD00_0000,           64'h401, 8'h01, 64'hAB,           3, 64'h0,                  1'b0};

      rst = 1'b1; valid = 1'b0; we = 1'b0; gnt = 1'b0; rvalid = 1'b0;
      f3 = '0; addr = '0; wdata = '0; rdata = '0; sel = 2'd0;

      // Reset state of every instance.
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         chk($sformatf("rst%0d_ready", s), 64'(o_ready), 64'd1);
         chk($sformatf("rst%0d_mreq", s), 64'(o_mreq), 64'd0);
         chk($sformatf("rst%0d_resp", s), 64'(o_resp), 64'd0);
         chk($sformatf("rst%0d_maddr", s), o_maddr, 64'd0);
         chk($sformatf("rst%0d_strb", s), 64'(o_strb), 64'd0);
      end
      sel = 2'd0;
      rst = 1'b0;

      // Table: consecutive entries also exercise back-to-back acceptance.
      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // Grant withheld for three cycles: beat held stable, not ready.
      @(negedge clk);
      sel = 2'd0; we = 1'b1; f3 = 3'b010; addr = 64'h3000; wdata = 64'h1122_3344; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stall%0d_mreq", i), 64'(o_mreq), 64'd1);
         chk($sformatf("stall%0d_addr", i), o_maddr, 64'h600);
         chk($sformatf("stall%0d_strb", i), 64'(o_strb), 64'h0F);
         chk($sformatf("stall%0d_ready", i), 64'(o_ready), 64'd0);
         @(negedge clk);
      end
      chk("stall_last_mreq", 64'(o_mreq), 64'd1);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      chk("stall_resp", 64'(o_resp), 64'd1);
      chk("stall_err", 64'(o_err), 64'd0);

      // Reset while waiting for read data, then a stray rvalid in IDLE.
      @(negedge clk);
      we = 1'b0; f3 = 3'b010; addr = 64'h1004; wdata = '0; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("rstw_req0", 64'(o_mreq), 64'd1);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      chk("rstw_wait_ready", 64'(o_ready), 64'd0);
      chk("rstw_wait_mreq", 64'(o_mreq), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstw_ready", 64'(o_ready), 64'd1);
      chk("rstw_mreq", 64'(o_mreq), 64'd0);
      chk("rstw_resp", 64'(o_resp), 64'd0);
      rvalid = 1'b1; rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      @(negedge clk);
      rvalid = 1'b0;
      chk("stray_rvalid_resp", 64'(o_resp), 64'd0);
      chk("stray_rvalid_ready", 64'(o_ready), 64'd1);
      run_vec(vecs[0], 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
